// File: rtl/i2c_temp_responder.sv
// i2c_temp_responder
//   Read-only I2C target that returns a 16-bit temperature value, high byte
//   first, MSB first. A snapshot of temp_data is taken when the address is
//   acknowledged and is replayed (wrapping high/low) for as long as the
//   initiator keeps ACKing. Write requests and foreign addresses are NACKed.
//
// Ports
//   clk        system clock (50 MHz)
//   rst_n      asynchronous active-low reset
//   scl        I2C clock from the initiator, asynchronous to clk
//   sda        I2C data, open-drain (driven 0 or released, never 1)
//   temp_data  temperature register value
//   busy       high while the state machine is not idle
//   addr_hit   one-clk pulse when a read address matches DEV_ADDR
//   rd_done    one-clk pulse when the initiator's ACK/NACK after the low
//              byte is sampled
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | bus free or not yet joined; waits for START
// S_ADDR      | shifting in the 8-bit address/RW byte
// S_ADDR_ACK  | driving ACK for a matching read address
// S_TX        | presenting the bits of the selected snapshot byte
// S_MACK      | sampling the initiator's ACK/NACK after a data byte
// S_WAIT_STOP | not addressed or NACKed; bus ignored until START/STOP

module i2c_temp_responder #(
  parameter logic [6:0] DEV_ADDR = 7'b1001000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl,
  inout  wire         sda,
  input  logic [15:0] temp_data,
  output logic        busy,
  output logic        addr_hit,
  output logic        rd_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_TX,
    S_MACK,
    S_WAIT_STOP
  } state_t;

  logic scl_s1_q, scl_s2_q, scl_d_q;
  logic sda_s1_q, sda_s2_q, sda_d_q;

  state_t      state_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [15:0] snap_q;
  logic        byte_sel_q;   // 0: snapshot[15:8], 1: snapshot[7:0]
  logic        mack_ack_q;   // ACK seen in MACK, waiting for scl_fall
  logic        sda_oe_q;
  logic        busy_q;
  logic        addr_hit_q;
  logic        rd_done_q;

  logic       start_det, stop_det, scl_rise, scl_fall;
  logic [7:0] tx_byte;
  logic [2:0] tx_idx;

  // Two-stage synchronizers plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_d_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_d_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl;
      scl_s2_q <= scl_s1_q;
      scl_d_q  <= scl_s2_q;
      sda_s1_q <= sda;
      sda_s2_q <= sda_s1_q;
      sda_d_q  <= sda_s2_q;
    end
  end

  assign start_det = scl_s2_q & sda_d_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & ~sda_d_q & sda_s2_q;
  assign scl_rise  = scl_s2_q & ~scl_d_q;
  assign scl_fall  = ~scl_s2_q & scl_d_q;

  always_comb begin
    tx_byte = byte_sel_q ? snap_q[7:0] : snap_q[15:8];
    tx_idx  = 3'd7 - bit_cnt_q[2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      snap_q     <= 16'd0;
      byte_sel_q <= 1'b0;
      mack_ack_q <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      addr_hit_q <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      addr_hit_q <= 1'b0;
      rd_done_q  <= 1'b0;
      if (start_det) begin
        // Also handles repeated START from any state.
        state_q    <= S_ADDR;
        bit_cnt_q  <= 4'd0;
        mack_ack_q <= 1'b0;
        sda_oe_q   <= 1'b0;
        busy_q     <= 1'b1;
      end else if (stop_det) begin
        state_q    <= S_IDLE;
        bit_cnt_q  <= 4'd0;
        mack_ack_q <= 1'b0;
        sda_oe_q   <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          S_ADDR: begin
            if (scl_rise && bit_cnt_q != 4'd8) begin
              shift_q   <= {shift_q[6:0], sda_s2_q};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              bit_cnt_q <= 4'd0;
              if (shift_q[7:1] == DEV_ADDR && shift_q[0]) begin
                sda_oe_q   <= 1'b1;
                addr_hit_q <= 1'b1;
                state_q    <= S_ADDR_ACK;
              end else begin
                state_q <= S_WAIT_STOP;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              snap_q     <= temp_data;
              byte_sel_q <= 1'b0;
              sda_oe_q   <= ~temp_data[15];
              bit_cnt_q  <= 4'd1;
              state_q    <= S_TX;
            end
          end
          S_TX: begin
            // bit_cnt_q counts bits already presented for this byte.
            if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q   <= 1'b0;
                mack_ack_q <= 1'b0;
                state_q    <= S_MACK;
              end else begin
                sda_oe_q  <= ~tx_byte[tx_idx];
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          S_MACK: begin
            if (scl_rise && !mack_ack_q) begin
              if (byte_sel_q) rd_done_q <= 1'b1;
              if (!sda_s2_q) begin
                byte_sel_q <= ~byte_sel_q;
                mack_ack_q <= 1'b1;
              end else begin
                state_q <= S_WAIT_STOP;
              end
            end else if (scl_fall && mack_ack_q) begin
              // byte_sel_q already points at the next byte here.
              sda_oe_q   <= ~tx_byte[7];
              bit_cnt_q  <= 4'd1;
              mack_ack_q <= 1'b0;
              state_q    <= S_TX;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign busy     = busy_q;
  assign addr_hit = addr_hit_q;
  assign rd_done  = rd_done_q;

endmodule

// File: tb/tb_i2c_temp_responder.sv
module tb_i2c_temp_responder;
  localparam logic [6:0] DEV = 7'b1001000;
  localparam int T = 52;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m_low = 1'b0;
  logic [15:0] temp_data = 16'h0000;
  wire         sda;
  logic        busy, addr_hit, rd_done;

  pullup (sda);
  assign sda = sda_m_low ? 1'b0 : 1'bz;

  i2c_temp_responder #(.DEV_ADDR(DEV)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl_m), .sda(sda), .temp_data(temp_data),
    .busy(busy), .addr_hit(addr_hit), .rd_done(rd_done)
  );

  always #10 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, last_evt_cyc = 0, last_fall_cyc = -1000;
  int hit_cnt = 0, done_cnt = 0, exp_hits = 0, exp_done = 0;
  bit exp_busy = 1'b0, may_drive = 1'b0;
  bit ah_prev = 1'b0, rd_prev = 1'b0;
  logic [7:0] got [0:3];
  bit got_ack;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b, output logic r);
    sda_m_low = !b;
    wait_clk(T);
    scl_m = 1'b1;
    wait_clk(T / 2);
    r = sda;
    wait_clk(T - T / 2);
    scl_m = 1'b0;
    last_fall_cyc = cyc;
    wait_clk(10);
  endtask

  task automatic start_cond();
    may_drive = 1'b0;
    sda_m_low = 1'b0;
    wait_clk(T);
    scl_m = 1'b1;
    wait_clk(T);
    sda_m_low = 1'b1;
    exp_busy = 1'b1;
    last_evt_cyc = cyc;
    wait_clk(T);
    scl_m = 1'b0;
    last_fall_cyc = cyc;
    wait_clk(10);
  endtask

  task automatic stop_cond();
    may_drive = 1'b0;
    sda_m_low = 1'b1;
    wait_clk(T);
    scl_m = 1'b1;
    wait_clk(T);
    sda_m_low = 1'b0;
    exp_busy = 1'b0;
    last_evt_cyc = cyc;
    wait_clk(T);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit slave_acks, output bit ack);
    logic r;
    may_drive = 1'b0;
    for (int i = 7; i >= 0; i--) send_bit(d[i], r);
    may_drive = slave_acks;
    send_bit(1'b1, r);
    ack = (r === 1'b0);
  endtask

  task automatic read_byte(input bit slave_drives, input bit chg, input logic [15:0] nt,
                           output logic [7:0] d);
    logic r;
    may_drive = slave_drives;
    for (int i = 7; i >= 0; i--) begin
      if (chg && i == 4) temp_data = nt;
      send_bit(1'b1, r);
      d[i] = r;
    end
  endtask

  task automatic master_ack(input bit ack);
    logic r;
    if (!ack) may_drive = 1'b0;
    send_bit(!ack, r);
  endtask

  // Transaction-level reference: the target ACKs only a read of DEV, then
  // returns snapshot bytes hi, lo, hi, ... taken at address-ACK time.
  task automatic do_txn(input logic [7:0] abyte, input int nbytes, input bit chg,
                        input logic [15:0] nt, input bit do_stop);
    bit exp_ack, ack;
    logic [15:0] snap;
    logic [7:0] d, e;
    exp_ack = (abyte[7:1] == DEV) && abyte[0];
    snap = 16'h0;
    start_cond();
    send_byte(abyte, exp_ack, ack);
    chk("addr_ack", 16'(ack), 16'(exp_ack));
    got_ack = ack;
    if (exp_ack) begin
      snap = temp_data;
      exp_hits++;
    end
    if (abyte[0]) begin
      for (int i = 0; i < nbytes; i++) begin
        read_byte(exp_ack, chg && i == 0, nt, d);
        if (!exp_ack) e = 8'hFF;
        else if (i % 2 == 1) e = snap[7:0];
        else e = snap[15:8];
        chk("rd_byte", 16'(d), 16'(e));
        if (i < 4) got[i] = d;
        if (exp_ack && i % 2 == 1) exp_done++;
        master_ack(i < nbytes - 1);
      end
    end else begin
      send_byte(8'($urandom_range(0, 255)), 1'b0, ack);
      chk("wr_data_nack", 16'(ack), 16'd0);
    end
    if (do_stop) stop_cond();
    chk("addr_hit_count", 16'(hit_cnt), 16'(exp_hits));
    chk("rd_done_count", 16'(done_cnt), 16'(exp_done));
  endtask

  initial begin
    fork
      begin : cmp
        forever begin
          @(negedge clk);
          cyc++;
          if (addr_hit === 1'b1) begin
            hit_cnt++;
            checks++;
            if (ah_prev) begin
              errors++;
              $display("FAIL addr_hit_width: high 2 cycles, expected 1 (t=%0t)", $time);
            end
          end
          if (rd_done === 1'b1) begin
            done_cnt++;
            checks++;
            if (rd_prev) begin
              errors++;
              $display("FAIL rd_done_width: high 2 cycles, expected 1 (t=%0t)", $time);
            end
          end
          ah_prev = (addr_hit === 1'b1);
          rd_prev = (rd_done === 1'b1);
          if (rst_n && !sda_m_low && !may_drive && (cyc - last_fall_cyc > 12)) begin
            checks++;
            if (sda !== 1'b1) begin
              errors++;
              $display("FAIL sda_released: got %b expected 1 (t=%0t)", sda, $time);
            end
          end
          if (cyc - last_evt_cyc > 6) begin
            checks++;
            if (busy !== exp_busy) begin
              errors++;
              $display("FAIL busy: got %b expected %b (t=%0t)", busy, exp_busy, $time);
            end
          end
        end
      end
      begin : stim
        bit ack;
        logic r;
        logic [7:0] ab;
        int sel;
        wait_clk(5);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_addr_hit", 16'(addr_hit), 16'd0);
        chk("rst_rd_done", 16'(rd_done), 16'd0);
        chk("rst_sda", 16'(sda), 16'd1);
        rst_n = 1'b1;
        wait_clk(20);

        // Basic two-byte read.
        temp_data = 16'h1980;
        do_txn(8'h91, 2, 1'b0, 16'h0, 1'b1);
        chk("basic_hi", 16'(got[0]), 16'h0019);
        chk("basic_lo", 16'(got[1]), 16'h0080);
        chk("basic_hits", 16'(hit_cnt), 16'd1);
        chk("basic_done", 16'(done_cnt), 16'd1);

        // Foreign address and write request.
        do_txn(8'h93, 1, 1'b0, 16'h0, 1'b1);
        chk("foreign_ack", 16'(got_ack), 16'd0);
        do_txn(8'h90, 1, 1'b0, 16'h0, 1'b1);
        chk("write_ack", 16'(got_ack), 16'd0);

        // temp_data change during the first data byte.
        temp_data = 16'h1980;
        do_txn(8'h91, 2, 1'b1, 16'h0000, 1'b1);
        chk("snap_hi", 16'(got[0]), 16'h0019);
        chk("snap_lo", 16'(got[1]), 16'h0080);
        do_txn(8'h91, 2, 1'b0, 16'h0, 1'b1);
        chk("snap_next_hi", 16'(got[0]), 16'h0000);
        chk("snap_next_lo", 16'(got[1]), 16'h0000);

        // Reset while the target drives a 0 data bit.
        temp_data = 16'h1980;
        start_cond();
        send_byte(8'h91, 1'b1, ack);
        chk("rst_case_ack", 16'(ack), 16'd1);
        exp_hits++;
        may_drive = 1'b1;
        sda_m_low = 1'b0;
        wait_clk(T);
        scl_m = 1'b1;
        wait_clk(T / 2);
        chk("tx_bit7_low", 16'(sda), 16'd0);
        rst_n = 1'b0;
        may_drive = 1'b0;
        exp_busy = 1'b0;
        last_evt_cyc = cyc;
        #1;
        chk("rst_async_release", 16'(sda), 16'd1);
        wait_clk(3);
        chk("rst_mid_busy", 16'(busy), 16'd0);
        rst_n = 1'b1;
        wait_clk(T - T / 2);
        scl_m = 1'b0;
        last_fall_cyc = cyc;
        wait_clk(10);
        for (int i = 0; i < 7; i++) begin
          send_bit(1'b1, r);
          chk("post_rst_ignored", 16'(r), 16'd1);
        end
        send_bit(1'b1, r);
        stop_cond();
        temp_data = 16'h5AC3;
        do_txn(8'h91, 2, 1'b0, 16'h0, 1'b1);
        chk("post_rst_hi", 16'(got[0]), 16'h005A);
        chk("post_rst_lo", 16'(got[1]), 16'h00C3);

        // Repeated START after the first data byte.
        temp_data = 16'hA5F0;
        do_txn(8'h91, 1, 1'b0, 16'h0, 1'b0);
        chk("rs_first_hi", 16'(got[0]), 16'h00A5);
        temp_data = 16'h3C7E;
        do_txn(8'h91, 2, 1'b0, 16'h0, 1'b1);
        chk("rs_hi", 16'(got[0]), 16'h003C);
        chk("rs_lo", 16'(got[1]), 16'h007E);

        // Randomized transactions, including wrap-around reads.
        for (int n = 0; n < 10; n++) begin
          sel = int'($urandom_range(0, 9));
          if (sel < 6) ab = 8'h91;
          else if (sel == 6) ab = 8'h90;
          else ab = 8'($urandom_range(0, 255));
          temp_data = 16'($urandom_range(0, 65535));
          do_txn(ab, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 65535)), 1'b1);
        end
        wait_clk(20);
      end
      begin : wd
        repeat (95000) @(posedge clk);
        errors++;
        $display("FAIL watchdog: cycle budget exhausted, expected completion");
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
